build_block: RTL
================

# build_block

Collects a block of bytes streamed one at a time from a request/valid byte source and assembles them into a packed block. It is the receive side of the byte-streaming interface used by the block disassembler. It issues one request pulse per byte, captures each returned byte in order, and presents the completed block on a valid/ready output handshake. A watchdog aborts the block if the source stops answering.

## Interface
Parameters:
- NUM_BYTES, 16: bytes per block; block width is NUM_BYTES×8.
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT for one byte before abort; minimum 1.

Ports:
- clk_in  input  1  sole clock, all logic on rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- start  input  1  begin assembling a new block; sampled only in IDLE.
- byte_in  input  8  returned byte from source.
- byte_valid_in  input  1  byte_in valid this cycle.
- request_out  output  1  one-cycle pulse asking the source for the next byte.
- block_out  output  [NUM_BYTES-1:0][7:0]  assembled block; byte k received lands in block_out[k].
- block_valid_out  output  1  block_out complete and stable.
- block_ready_in  input  1  consumer accepts block when high with block_valid_out.
- busy_out  output  1  high in any state other than IDLE.
- error_out  output  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, REQUEST, WAIT, DONE.
- IDLE:
  - On start → REQUEST.
  - Clear byte counter and watchdog.
- REQUEST:
  - request_out=1 for this cycle only.
  - Always → WAIT next cycle.
  - byte_valid_in in this state is ignored.
- WAIT:
  - On byte_valid_in, write byte_in to block_out[count] and reset the watchdog.
  - If count==NUM_BYTES-1 → DONE; else count+1 and → REQUEST.
  - Without valid, watchdog increments. When it reaches TIMEOUT_CYCLES: error_out=1 for one cycle, → IDLE, partial block discarded (block_valid_out never asserted).
- DONE:
  - block_valid_out=1 and block_out frozen.
  - On block_valid_out && block_ready_in → IDLE; block_valid_out low the following cycle.
- Only one request is outstanding at a time.
- byte_valid_in outside WAIT is dropped and does not advance the count.
- start is ignored outside IDLE, including in the cycle of the DONE handshake.
- Byte counter width is $clog2(NUM_BYTES); it wraps only via reset to 0 in IDLE.
- Watchdog width is $clog2(TIMEOUT_CYCLES+1).

## Timing
- All outputs are registered.
- Reset values: request_out=0, block_out=0, block_valid_out=0, busy_out=0, error_out=0, state=IDLE, counters=0.
- rst_in asserted mid-block clears everything immediately (asynchronous); no error pulse, no partial block.
- Start sampled at cycle 0:
  - request_out high in cycle 1.
  - If the source answers one cycle after each request, byte k is captured at cycle 2k+2.
  - The last byte (k=15) is captured at cycle 32; block_valid_out is high from cycle 33.
- Throughput is at most one byte per 2 cycles.
- block_ready_in high while block_valid_out is high: IDLE next cycle. The earliest next start is accepted the cycle after that.
- byte_valid_in and watchdog expiry in the same WAIT cycle: the byte wins; it is captured and no error.

## Structure
- Shared package holds:
  - the state enum typedef (IDLE, REQUEST, WAIT, DONE);
  - BLOCK_BYTES=16 and BYTE_W=8, shared with the block disassembler.
- One natural sub-module, `watchdog_counter`:
  - ports: clear, enable, expired;
  - parameter: TIMEOUT_CYCLES.
- The remainder (FSM, byte counter, block register) lives in build_block.

## Test plan
- Reset then start; source returns 0x00..0x0F, one cycle after each request → block_out[k]=k, block_valid_out rises at cycle 33, exactly 16 request pulses.
- Source delays 0–5 random cycles per byte, bytes 0xA0+k → block_out[k]=0xA0+k; never two requests without an intervening valid.
- Hold block_ready_in low 10 cycles in DONE while toggling start and byte_valid_in → block_out unchanged; no request_out; state stays DONE until ready.
- Source stops after byte 7; TIMEOUT_CYCLES=64 → error_out pulses once, 64 cycles after entering WAIT; busy_out=0 next cycle; block_valid_out never high.
- Assert rst_in asynchronously mid-block (after byte 5) → all outputs 0 immediately. A fresh start then assembles a full 16-byte block correctly.
- Spurious byte_valid_in in IDLE and in REQUEST cycles (value 0xFF) → not captured; final block contains only the responses to requests.

Source files
------------

// File: rtl/build_block_pkg.sv
// Shared definitions for the byte-streaming block builder/disassembler pair.
// Holds the FSM state type and the common block geometry.
package build_block_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT,
        DONE
    } state_e;

endpackage

// File: rtl/build_block_watchdog_counter.sv
// Watchdog for one outstanding byte request.
// Ports: clk/rst, clear (zero count), enable (count one idle cycle),
// expired (this enabled cycle is the TIMEOUT_CYCLES-th in a row).
module watchdog_counter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] count_q;
    logic [WD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WD_W'(1);
        end
    end

    // Fires in the cycle that would bring the count up to TIMEOUT_CYCLES,
    // so the caller can register its abort on the same edge.
    assign expired = enable && !clear && (count_q == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/build_block.sv
// Receive side of the byte stream: requests bytes one at a time,
// packs them into block_out, and hands the block over on valid/ready.
// Ports: clk_in/rst_in, start, byte_in/byte_valid_in (source reply),
// request_out (byte request pulse), block_out/block_valid_out/
// block_ready_in (block handshake), busy_out, error_out (timeout pulse).
module build_block
    import build_block_pkg::*;
#(
    parameter int NUM_BYTES      = BLOCK_BYTES,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              start,
    input  logic [BYTE_W-1:0]                 byte_in,
    input  logic                              byte_valid_in,
    output logic                              request_out,
    output logic [NUM_BYTES-1:0][BYTE_W-1:0]  block_out,
    output logic                              block_valid_out,
    input  logic                              block_ready_in,
    output logic                              busy_out,
    output logic                              error_out
);

    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BYTES - 1);

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [NUM_BYTES-1:0][BYTE_W-1:0]  block_q, block_d;
    logic                              req_q, req_d;
    logic                              valid_q, valid_d;
    logic                              busy_q, busy_d;
    logic                              err_q, err_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    watchdog_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wd (
        .clk    (clk_in),
        .rst    (rst_in),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    // Output registers are loaded on the edge that enters the state
    // they belong to, so every output is a plain flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        block_d   = block_q;
        req_d     = 1'b0;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        err_d     = 1'b0;
        wd_clear  = 1'b1;
        wd_enable = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = REQUEST;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            REQUEST: begin
                state_d = WAIT;
            end
            WAIT: begin
                wd_clear  = byte_valid_in;
                wd_enable = !byte_valid_in;
                // A byte arriving on the expiry cycle still counts.
                if (byte_valid_in) begin
                    block_d[cnt_q] = byte_in;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        state_d = REQUEST;
                        req_d   = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                if (block_ready_in) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            block_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            block_q <= block_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign request_out     = req_q;
    assign block_out       = block_q;
    assign block_valid_out = valid_q;
    assign busy_out        = busy_q;
    assign error_out       = err_q;

endmodule
